// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the Quinta pipeline sequencer.
// Provides stage index constants and the per-stage update action encoding.
package pipeline_ctrl_pkg;

    localparam int unsigned STAGE_IF  = 0;
    localparam int unsigned STAGE_ID  = 1;
    localparam int unsigned STAGE_EX  = 2;
    localparam int unsigned STAGE_MEM = 3;
    localparam int unsigned STAGE_WB  = 4;

    // What a stage register does at the next edge.
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_SQUASH  = 2'd3
    } stage_act_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the core datapath and the pipeline sequencer.
// master: datapath side (drives events, reads enables/valids/counters).
// slave : pipeline_ctrl side.
interface pipeline_ctrl_if #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned CNT_W      = 32
);
    logic                  fetch_valid;
    logic [NUM_STAGES-1:0] stall_req;
    logic                  redirect;
    logic [REG_W-1:0]      dec_rs1;
    logic [REG_W-1:0]      dec_rs2;
    logic                  dec_use_rs1;
    logic                  dec_use_rs2;
    logic                  ex_mem_read;
    logic [REG_W-1:0]      ex_rd;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [NUM_STAGES-1:0] stage_en;
    logic                  fetch_hold;
    logic                  load_use;
    logic                  redirect_taken;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output fetch_valid, stall_req, redirect, dec_rs1, dec_rs2,
               dec_use_rs1, dec_use_rs2, ex_mem_read, ex_rd,
        input  stage_valid, stage_en, fetch_hold, load_use, redirect_taken,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  fetch_valid, stall_req, redirect, dec_rs1, dec_rs2,
               dec_use_rs1, dec_use_rs2, ex_mem_read, ex_rd,
        output stage_valid, stage_en, fetch_hold, load_use, redirect_taken,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_load_use_detector.sv
// Combinational load-use hazard comparator.
// Ports: id_valid/ex_valid (stage 1/2 valid), ex_mem_read, ex_rd,
//        dec_rs1/dec_rs2 with use flags -> load_use.
module load_use_detector #(
    parameter int unsigned REG_W = 5
) (
    input  logic             id_valid,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    output logic             load_use
);
    logic match_rs1;
    logic match_rs2;

    assign match_rs1 = dec_use_rs1 && (dec_rs1 == ex_rd);
    assign match_rs2 = dec_use_rs2 && (dec_rs2 == ex_rd);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
                      && (match_rs1 || match_rs2);
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: owns per-stage valid bits, drives per-stage load
// enables and merges load-use, external hold and redirect events.
// Ports: clk, rst (sync, active-high), bus (pipeline_ctrl_if.slave) carrying
//        event inputs, stage_valid/stage_en/fetch_hold/load_use/
//        redirect_taken and the stall/flush performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 5,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned REG_W       = 5,
    parameter int unsigned CNT_W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);
    logic [NUM_STAGES-1:1] valid_q;
    logic [NUM_STAGES-1:1] valid_d;
    logic [NUM_STAGES-1:0] valid;
    logic [NUM_STAGES-1:0] ext_hold;
    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] stage_en;
    logic                  load_use;
    logic                  redirect_taken;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    // Effective valids; everything reads as empty while in reset.
    assign valid = rst ? '0 : {valid_q, bus.fetch_valid};

    load_use_detector #(.REG_W(REG_W)) u_load_use (
        .id_valid    (valid[STAGE_ID]),
        .ex_valid    (valid[STAGE_EX]),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .dec_rs1     (bus.dec_rs1),
        .dec_rs2     (bus.dec_rs2),
        .dec_use_rs1 (bus.dec_use_rs1),
        .dec_use_rs2 (bus.dec_use_rs2),
        .load_use    (load_use)
    );

    // A held branch stage defers the redirect; the branch unit keeps it asserted.
    assign redirect_taken = bus.redirect && valid[FLUSH_DEPTH] && !ext_hold[FLUSH_DEPTH];

    assign stage_en[STAGE_IF] = !rst && !hold[STAGE_IF];

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_hold
            // Backpressure: a stage is held if it or anything downstream is.
            assign ext_hold[k] = |bus.stall_req[NUM_STAGES-1:k];
            if (k <= STAGE_ID) begin : g_lu
                // A redirect squashes the dependent instruction, so no stall.
                assign hold[k] = ext_hold[k] || (load_use && !redirect_taken);
            end else begin : g_nolu
                assign hold[k] = ext_hold[k];
            end
        end

        for (k = 1; k < NUM_STAGES; k++) begin : g_stage
            stage_act_e act;

            always_comb begin
                act = ACT_ADVANCE;
                if (hold[k]) begin
                    act = ACT_HOLD;
                end else if (hold[k-1]) begin
                    act = ACT_BUBBLE;
                end else if (redirect_taken && (k <= FLUSH_DEPTH)) begin
                    act = ACT_SQUASH;
                end
            end

            assign stage_en[k] = !rst && (act != ACT_HOLD);
            assign valid_d[k]  = (act == ACT_HOLD)    ? valid[k]   :
                                 (act == ACT_ADVANCE) ? valid[k-1] : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hold[STAGE_IF] && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stage_valid    = valid;
    assign bus.stage_en       = stage_en;
    assign bus.fetch_hold     = rst || hold[STAGE_IF];
    assign bus.load_use       = load_use;
    assign bus.redirect_taken = redirect_taken;
    assign bus.stall_cnt      = stall_cnt;
    assign bus.flush_cnt      = flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl (5 stages, branch in stage 2).
module tb_pipeline_ctrl;
    typedef enum int {S_VALID, S_EN, S_FHOLD, S_LU, S_RT, S_SCNT, S_FCNT} sig_e;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    string       step_q[$];
    sig_e        sig_q[$];
    logic [31:0] val_q[$];

    pipeline_ctrl_if #(.NUM_STAGES(5), .REG_W(5), .CNT_W(32)) bus ();

    pipeline_ctrl #(
        .NUM_STAGES (5),
        .FLUSH_DEPTH(2),
        .REG_W      (5),
        .CNT_W      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(sig_e s);
        case (s)
            S_VALID: return 32'(bus.stage_valid);
            S_EN:    return 32'(bus.stage_en);
            S_FHOLD: return 32'(bus.fetch_hold);
            S_LU:    return 32'(bus.load_use);
            S_RT:    return 32'(bus.redirect_taken);
            S_SCNT:  return bus.stall_cnt;
            default: return bus.flush_cnt;
        endcase
    endfunction

    task automatic exp(input string step, input sig_e s, input logic [31:0] v);
        step_q.push_back(step);
        sig_q.push_back(s);
        val_q.push_back(v);
    endtask

    task automatic check_sb();
        string       step;
        sig_e        s;
        logic [31:0] e;
        logic [31:0] obs;
        while (val_q.size() > 0) begin
            step = step_q.pop_front();
            s    = sig_q.pop_front();
            e    = val_q.pop_front();
            obs  = observe(s);
            checks++;
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s/%s observed=%0h expected=%0h", step, s.name(), obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        bus.stall_req   = '0;
        bus.redirect    = 1'b0;
        bus.dec_rs1     = '0;
        bus.dec_rs2     = '0;
        bus.dec_use_rs1 = 1'b0;
        bus.dec_use_rs2 = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd       = '0;
    endtask

    task automatic refill(input string step, input int n);
        for (int i = 0; i < n; i++) tick();
        exp(step, S_VALID, 32'h1f);
        check_sb();
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset with stray events present: all must be ignored.
        clear_events();
        rst             = 1'b1;
        bus.fetch_valid = 1'b1;
        bus.redirect    = 1'b1;
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd3;
        bus.dec_rs1     = 5'd3;
        bus.dec_use_rs1 = 1'b1;
        tick();
        tick();
        exp("rst", S_VALID, 32'h0);
        exp("rst", S_EN, 32'h0);
        exp("rst", S_FHOLD, 32'h1);
        exp("rst", S_LU, 32'h0);
        exp("rst", S_RT, 32'h0);
        exp("rst", S_SCNT, 32'h0);
        exp("rst", S_FCNT, 32'h0);
        check_sb();

        // Free run: valids fill one stage per cycle.
        rst = 1'b0;
        clear_events();
        #1;
        exp("free0", S_VALID, 32'h01);
        exp("free0", S_EN, 32'h1f);
        exp("free0", S_FHOLD, 32'h0);
        check_sb();
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp("free_fill", S_VALID, 32'((1 << (i + 1)) - 1));
            check_sb();
        end
        for (int i = 0; i < 5; i++) tick();
        exp("free_end", S_VALID, 32'h1f);
        exp("free_end", S_SCNT, 32'h0);
        exp("free_end", S_FCNT, 32'h0);
        check_sb();

        // Load-use on rs1: one bubble into stage 2.
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd5;
        bus.dec_rs1     = 5'd5;
        bus.dec_use_rs1 = 1'b1;
        #1;
        exp("lu", S_LU, 32'h1);
        exp("lu", S_FHOLD, 32'h1);
        exp("lu", S_EN, 32'h1c);
        check_sb();
        tick();
        exp("lu_next", S_VALID, 32'h1b);
        exp("lu_next", S_LU, 32'h0);
        exp("lu_next", S_FHOLD, 32'h0);
        exp("lu_next", S_SCNT, 32'h1);
        check_sb();
        clear_events();
        tick();
        exp("lu_drain1", S_VALID, 32'h17);
        check_sb();
        tick();
        exp("lu_drain2", S_VALID, 32'h0f);
        check_sb();
        refill("lu_refill", 1);

        // Load to x0: no hazard.
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd0;
        bus.dec_rs1     = 5'd0;
        bus.dec_use_rs1 = 1'b1;
        #1;
        exp("x0", S_LU, 32'h0);
        exp("x0", S_FHOLD, 32'h0);
        exp("x0", S_EN, 32'h1f);
        check_sb();
        tick();
        exp("x0_next", S_VALID, 32'h1f);
        exp("x0_next", S_SCNT, 32'h1);
        check_sb();

        // rs2 match only counts when rs2 is actually used.
        bus.ex_rd       = 5'd7;
        bus.dec_rs2     = 5'd7;
        bus.dec_use_rs2 = 1'b0;
        #1;
        exp("rs2_unused", S_LU, 32'h0);
        check_sb();
        bus.dec_use_rs2 = 1'b1;
        #1;
        exp("rs2", S_LU, 32'h1);
        exp("rs2", S_EN, 32'h1c);
        check_sb();
        tick();
        exp("rs2_next", S_VALID, 32'h1b);
        exp("rs2_next", S_SCNT, 32'h2);
        check_sb();
        clear_events();
        refill("rs2_refill", 3);

        // Plain redirect: stages 1-2 squashed, branch moves to stage 3.
        bus.redirect = 1'b1;
        #1;
        exp("redir", S_RT, 32'h1);
        exp("redir", S_EN, 32'h1f);
        exp("redir", S_FHOLD, 32'h0);
        check_sb();
        tick();
        bus.redirect = 1'b0;
        #1;
        exp("redir_next", S_VALID, 32'h19);
        exp("redir_next", S_FCNT, 32'h1);
        exp("redir_next", S_RT, 32'h0);
        check_sb();
        refill("redir_refill", 4);

        // Redirect with load-use: redirect wins, no stall.
        bus.redirect    = 1'b1;
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd5;
        bus.dec_rs1     = 5'd5;
        bus.dec_use_rs1 = 1'b1;
        #1;
        exp("redir_lu", S_RT, 32'h1);
        exp("redir_lu", S_LU, 32'h1);
        exp("redir_lu", S_FHOLD, 32'h0);
        exp("redir_lu", S_EN, 32'h1f);
        check_sb();
        tick();
        clear_events();
        #1;
        exp("redir_lu_next", S_VALID, 32'h19);
        exp("redir_lu_next", S_FCNT, 32'h2);
        exp("redir_lu_next", S_SCNT, 32'h2);
        check_sb();
        refill("redir_lu_refill", 4);

        // Downstream stall defers a pending redirect.
        bus.stall_req = 5'b01000;
        bus.redirect  = 1'b1;
        #1;
        exp("stall_c1", S_RT, 32'h0);
        exp("stall_c1", S_FHOLD, 32'h1);
        exp("stall_c1", S_EN, 32'h10);
        check_sb();
        tick();
        exp("stall_c2", S_VALID, 32'h0f);
        exp("stall_c2", S_RT, 32'h0);
        check_sb();
        tick();
        exp("stall_c3", S_VALID, 32'h0f);
        exp("stall_c3", S_RT, 32'h0);
        check_sb();
        tick();
        bus.stall_req = '0;
        #1;
        exp("stall_c4", S_RT, 32'h1);
        exp("stall_c4", S_SCNT, 32'h5);
        exp("stall_c4", S_EN, 32'h1f);
        exp("stall_c4", S_VALID, 32'h0f);
        check_sb();
        tick();
        bus.redirect = 1'b0;
        #1;
        exp("stall_after", S_VALID, 32'h19);
        exp("stall_after", S_FCNT, 32'h3);
        check_sb();
        refill("stall_refill", 4);

        // Reset mid-stall with a redirect pending.
        bus.stall_req = 5'b00100;
        bus.redirect  = 1'b1;
        rst           = 1'b1;
        #1;
        exp("mid_rst", S_VALID, 32'h0);
        exp("mid_rst", S_EN, 32'h0);
        exp("mid_rst", S_FHOLD, 32'h1);
        exp("mid_rst", S_RT, 32'h0);
        exp("mid_rst", S_LU, 32'h0);
        check_sb();
        tick();
        exp("mid_rst_next", S_VALID, 32'h0);
        exp("mid_rst_next", S_SCNT, 32'h0);
        exp("mid_rst_next", S_FCNT, 32'h0);
        check_sb();
        rst           = 1'b0;
        bus.stall_req = '0;
        #1;
        exp("post_rst", S_VALID, 32'h01);
        exp("post_rst", S_RT, 32'h0);
        exp("post_rst", S_EN, 32'h1f);
        exp("post_rst", S_FHOLD, 32'h0);
        check_sb();
        tick();
        exp("post_rst_next", S_VALID, 32'h03);
        exp("post_rst_next", S_FCNT, 32'h0);
        exp("post_rst_next", S_SCNT, 32'h0);
        check_sb();
        bus.redirect = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
